// File: rtl/key_input_arbiter.sv
// Joypad input controller: drains the PS/2 keyboard FIFO, decodes set-2 make/break
// sequences into the joypad vector, and arbitrates against the UART key source.
module key_input_arbiter (
  input  logic        clk_4,
  input  logic        vb_rst,
  input  logic        ps2_ready,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_overflow,
  output logic        ps2_rdn,
  output logic        ps2_clrn,
  input  logic        ur_rdy,
  input  logic [7:0]  ur_dout,
  output logic        ur_rdy_clr,
  input  logic        src_sel,
  output logic [7:0]  key,
  output logic [15:0] last_code
);

  typedef enum logic [1:0] {IDLE, POP, GAP} pop_st_t;
  typedef enum logic [1:0] {PFX_NONE, PFX_BRK, PFX_EXT, PFX_EXTBRK} pfx_t;

  pop_st_t    state, state_nxt;
  pfx_t       pfx, pfx_nxt;
  logic [1:0] sel_sync, rdy_sync;
  logic       sel_s, rdy_s, sel_q, sel_chg;
  logic       armed;
  logic [7:0] byte_r;
  logic       ev_vld, ev_brk;
  logic [7:0] ev_mask;

  assign sel_s   = sel_sync[1];
  assign rdy_s   = rdy_sync[1];
  assign sel_chg = sel_s ^ sel_q;

  function automatic logic [7:0] key_map(input logic [7:0] code, input logic ext);
    key_map = '0;
    if (ext) begin
      case (code)
        8'h75: key_map = 8'h40;
        8'h72: key_map = 8'h80;
        8'h6B: key_map = 8'h20;
        8'h74: key_map = 8'h10;
        default: key_map = '0;
      endcase
    end else begin
      case (code)
        8'h1D: key_map = 8'h40;
        8'h1B: key_map = 8'h80;
        8'h1C: key_map = 8'h20;
        8'h23: key_map = 8'h10;
        8'h5A: key_map = 8'h08;
        8'h29: key_map = 8'h04;
        8'h4C: key_map = 8'h02;
        8'h52: key_map = 8'h01;
        default: key_map = '0;
      endcase
    end
  endfunction

  always_ff @(posedge clk_4 or posedge vb_rst) begin
    if (vb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ps2_ready) state_nxt = POP;
      POP:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ps2_overflow) state_nxt = IDLE;
  end

  // Prefix bytes only move the tracker; anything else is a key event that consumes it.
  always_comb begin
    pfx_nxt = pfx;
    ev_vld  = 1'b0;
    ev_brk  = 1'b0;
    ev_mask = '0;
    case (byte_r)
      8'hF0: pfx_nxt = (pfx == PFX_EXT || pfx == PFX_EXTBRK) ? PFX_EXTBRK : PFX_BRK;
      8'hE0: pfx_nxt = PFX_EXT;
      8'hE1: pfx_nxt = pfx;
      default: begin
        ev_vld  = 1'b1;
        ev_brk  = (pfx == PFX_BRK) || (pfx == PFX_EXTBRK);
        ev_mask = key_map(byte_r, (pfx == PFX_EXT) || (pfx == PFX_EXTBRK));
        pfx_nxt = PFX_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_4 or posedge vb_rst) begin
    if (vb_rst) begin
      sel_sync   <= '0;
      rdy_sync   <= '0;
      sel_q      <= 1'b0;
      armed      <= 1'b1;
      pfx        <= PFX_NONE;
      byte_r     <= '0;
      key        <= '0;
      last_code  <= '0;
      ps2_rdn    <= 1'b1;
      ps2_clrn   <= 1'b1;
      ur_rdy_clr <= 1'b0;
    end else begin
      sel_sync   <= {sel_sync[0], src_sel};
      rdy_sync   <= {rdy_sync[0], ur_rdy};
      sel_q      <= sel_s;
      ps2_clrn   <= ~ps2_overflow;
      ur_rdy_clr <= 1'b0;
      if (!rdy_s) armed <= 1'b1;

      if (ps2_overflow) begin
        ps2_rdn   <= 1'b1;
        pfx       <= PFX_NONE;
        last_code <= '0;
        if (!sel_s) key <= '0;
      end else begin
        case (state)
          IDLE: if (ps2_ready) begin
            byte_r  <= ps2_data;
            ps2_rdn <= 1'b0;
          end
          POP: begin
            ps2_rdn   <= 1'b1;
            last_code <= {last_code[7:0], byte_r};
            pfx       <= pfx_nxt;
            if (ev_vld && !sel_s) key <= ev_brk ? (key & ~ev_mask) : (key | ev_mask);
          end
          default: ;
        endcase
      end

      // A source switch wipes stale state and blocks a same-cycle UART accept.
      if (sel_chg) begin
        key   <= '0;
        pfx   <= PFX_NONE;
        armed <= 1'b1;
      end else if (sel_s && rdy_s && armed) begin
        key        <= ur_dout;
        ur_rdy_clr <= 1'b1;
        armed      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_input_arbiter.sv
// Self-checking bench for key_input_arbiter: byte-level FIFO driver plus a
// table-driven make/break reference model, randomized byte streams and UART bytes.
module tb_key_input_arbiter;

  logic        clk_4 = 1'b0;
  logic        vb_rst = 1'b1;
  logic        ps2_ready = 1'b0;
  logic [7:0]  ps2_data = '0;
  logic        ps2_overflow = 1'b0;
  logic        ps2_rdn, ps2_clrn;
  logic        ur_rdy = 1'b0;
  logic [7:0]  ur_dout = '0;
  logic        ur_rdy_clr;
  logic        src_sel = 1'b0;
  logic [7:0]  key;
  logic [15:0] last_code;

  key_input_arbiter dut (
    .clk_4(clk_4), .vb_rst(vb_rst),
    .ps2_ready(ps2_ready), .ps2_data(ps2_data), .ps2_overflow(ps2_overflow),
    .ps2_rdn(ps2_rdn), .ps2_clrn(ps2_clrn),
    .ur_rdy(ur_rdy), .ur_dout(ur_dout), .ur_rdy_clr(ur_rdy_clr),
    .src_sel(src_sel), .key(key), .last_code(last_code)
  );

  always #5 clk_4 = ~clk_4;

  int cyc = 0;
  always @(posedge clk_4) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pop_cyc;

  // Reference model: joypad state plus "extended"/"break" flags and lookup tables.
  logic [7:0]  m_key;
  logic [15:0] m_last;
  bit          m_ext, m_brk;
  int          plain_map [logic [7:0]];
  int          ext_map   [logic [7:0]];

  task automatic model_clear();
    m_key = '0; m_last = '0; m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] mask;
    mask = '0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
    else if (b == 8'hE1) begin end
    else begin
      if (m_ext && ext_map.exists(b)) mask = 8'(1 << ext_map[b]);
      if (!m_ext && plain_map.exists(b)) mask = 8'(1 << plain_map[b]);
      if (m_brk) m_key = m_key & ~mask;
      else       m_key = m_key | mask;
      m_ext = 0; m_brk = 0;
    end
    m_last = {m_last[7:0], b};
  endtask

  // Presents one byte as the FIFO head, waits for the pop, checks the decoded result.
  task automatic send_byte(input logic [7:0] b, input string tag);
    bit seen;
    seen = 0;
    ps2_data  = b;
    ps2_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_4);
      if (ps2_rdn === 1'b0) begin seen = 1; break; end
    end
    ps2_ready = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s pop_timeout byte=%h", tag, b);
      return;
    end
    pop_cyc = cyc;
    model_byte(b);
    @(negedge clk_4);
    checks++;
    if (ps2_rdn !== 1'b1) begin errors++; $display("FAIL %s rdn_width got=%b exp=1", tag, ps2_rdn); end
    checks++;
    if (key !== m_key) begin errors++; $display("FAIL %s key byte=%h got=%h exp=%h", tag, b, key, m_key); end
    checks++;
    if (last_code !== m_last) begin errors++; $display("FAIL %s last_code got=%h exp=%h", tag, last_code, m_last); end
    @(negedge clk_4);
  endtask

  task automatic test_reset();
    vb_rst = 1'b1;
    repeat (2) @(negedge clk_4);
    checks++;
    if ({key, last_code, ps2_rdn, ps2_clrn, ur_rdy_clr} !== {8'h00, 16'h0000, 3'b110}) begin
      errors++;
      $display("FAIL reset got key=%h last=%h rdn=%b clrn=%b clr=%b exp 00/0000/1/1/0",
               key, last_code, ps2_rdn, ps2_clrn, ur_rdy_clr);
    end
    vb_rst = 1'b0;
    model_clear();
    @(negedge clk_4);
  endtask

  task automatic test_ps2_basic();
    int c0, c1;
    send_byte(8'h1D, "basic_make");
    checks++;
    if (key !== 8'h40) begin errors++; $display("FAIL basic_make_key got=%h exp=40", key); end
    c0 = pop_cyc;
    send_byte(8'hF0, "basic_f0");
    c1 = pop_cyc;
    checks++;
    if (c1 - c0 != 3) begin errors++; $display("FAIL pop_spacing got=%0d exp=3", c1 - c0); end
    send_byte(8'h1D, "basic_break");
    checks++;
    if (pop_cyc - c1 != 3) begin errors++; $display("FAIL pop_spacing2 got=%0d exp=3", pop_cyc - c1); end
    checks++;
    if (key !== 8'h00 || last_code !== 16'hF01D) begin
      errors++; $display("FAIL basic_final got=%h/%h exp=00/F01D", key, last_code);
    end
  endtask

  task automatic test_ext();
    send_byte(8'hE0, "ext"); send_byte(8'h6B, "ext");
    send_byte(8'h4C, "ext");
    send_byte(8'hE0, "ext"); send_byte(8'hF0, "ext"); send_byte(8'h6B, "ext");
    checks++;
    if (key !== 8'h02) begin errors++; $display("FAIL ext_final got=%h exp=02", key); end
  endtask

  task automatic test_unmapped();
    logic [7:0] k0;
    k0 = key;
    send_byte(8'h1A, "unmapped"); send_byte(8'hF0, "unmapped"); send_byte(8'h1A, "unmapped");
    checks++;
    if (key !== k0) begin errors++; $display("FAIL unmapped_keep got=%h exp=%h", key, k0); end
    send_byte(8'h29, "unmapped_then_select");
    checks++;
    if (key[2] !== 1'b1) begin errors++; $display("FAIL select_after_unmapped got=%b exp=1", key[2]); end
  endtask

  task automatic test_random();
    logic [7:0] pool [13];
    logic [7:0] b;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h29, 8'h4C, 8'h52,
             8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1: b = 8'hF0;
        2, 3: b = 8'hE0;
        4:    b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'($urandom);
        default: b = pool[$urandom_range(0, 11)];
      endcase
      send_byte(b, "random");
    end
  endtask

  task automatic test_uart();
    logic [7:0] d, prev;
    int clr_cnt;
    src_sel = 1'b1;
    repeat (4) @(negedge clk_4);
    m_key = '0;
    checks++;
    if (key !== 8'h00) begin errors++; $display("FAIL uart_sel_clear got=%h exp=00", key); end
    prev = 8'h00;
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 8'hA5 : 8'($urandom);
      ur_dout = d;
      ur_rdy  = 1'b1;
      clr_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk_4);
        if (ur_rdy_clr === 1'b1) clr_cnt++;
        if (i == 2) begin
          checks++;
          if (key !== prev) begin errors++; $display("FAIL uart_early got=%h exp=%h", key, prev); end
        end
        if (i == 3) begin
          checks++;
          if (key !== d || ur_rdy_clr !== 1'b1) begin
            errors++; $display("FAIL uart_accept got=%h/%b exp=%h/1", key, ur_rdy_clr, d);
          end
        end
      end
      ur_rdy = 1'b0;
      repeat (3) begin
        @(negedge clk_4);
        if (ur_rdy_clr === 1'b1) clr_cnt++;
      end
      checks++;
      if (clr_cnt != 1) begin errors++; $display("FAIL uart_clr_pulses got=%0d exp=1", clr_cnt); end
      prev = d;
    end
    m_key = prev;
  endtask

  task automatic test_overflow();
    bit seen;
    src_sel = 1'b0;
    repeat (4) @(negedge clk_4);
    model_clear();
    checks++;
    if (key !== 8'h00) begin errors++; $display("FAIL ovf_sel_clear got=%h exp=00", key); end
    m_last = last_code;
    send_byte(8'h1D, "ovf_pre"); send_byte(8'h52, "ovf_pre");
    checks++;
    if (key !== 8'h41) begin errors++; $display("FAIL ovf_pre_key got=%h exp=41", key); end
    send_byte(8'hE0, "ovf_pre");
    ps2_data = 8'h1B; ps2_ready = 1'b1; seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_4);
      if (ps2_rdn === 1'b0) begin seen = 1; break; end
    end
    ps2_ready = 1'b0;
    ps2_overflow = 1'b1;
    @(negedge clk_4);
    ps2_overflow = 1'b0;
    checks++;
    if (!seen || ps2_clrn !== 1'b0 || key !== 8'h00 || last_code !== 16'h0 || ps2_rdn !== 1'b1) begin
      errors++;
      $display("FAIL ovf_effect seen=%b clrn=%b key=%h last=%h rdn=%b exp 1/0/00/0000/1",
               seen, ps2_clrn, key, last_code, ps2_rdn);
    end
    @(negedge clk_4);
    checks++;
    if (ps2_clrn !== 1'b1) begin errors++; $display("FAIL ovf_clrn_width got=%b exp=1", ps2_clrn); end
    model_clear();
    send_byte(8'h75, "ovf_post_prefix");
    send_byte(8'h1D, "ovf_post"); send_byte(8'hF0, "ovf_post"); send_byte(8'h1D, "ovf_post");
    checks++;
    if (key !== 8'h00 || last_code !== 16'hF01D) begin
      errors++; $display("FAIL ovf_break got=%h/%h exp=00/F01D", key, last_code);
    end
  endtask

  task automatic test_src_change();
    send_byte(8'h5A, "src_pre");
    checks++;
    if (key !== 8'h08) begin errors++; $display("FAIL src_pre_key got=%h exp=08", key); end
    src_sel = 1'b1;
    repeat (2) @(negedge clk_4);
    checks++;
    if (key !== 8'h08) begin errors++; $display("FAIL src_early got=%h exp=08", key); end
    @(negedge clk_4);
    checks++;
    if (key !== 8'h00) begin errors++; $display("FAIL src_clear got=%h exp=00", key); end
    src_sel = 1'b0;
    repeat (4) @(negedge clk_4);
    m_key = '0; m_ext = 0; m_brk = 0;
  endtask

  task automatic test_reset_mid_pop();
    bit seen;
    ps2_data = 8'h29; ps2_ready = 1'b1; seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_4);
      if (ps2_rdn === 1'b0) begin seen = 1; break; end
    end
    ps2_ready = 1'b0;
    #1 vb_rst = 1'b1;
    #1;
    checks++;
    if (!seen || {key, last_code, ps2_rdn, ps2_clrn, ur_rdy_clr} !== {8'h00, 16'h0000, 3'b110}) begin
      errors++;
      $display("FAIL rst_mid_pop seen=%b key=%h last=%h rdn=%b clrn=%b clr=%b",
               seen, key, last_code, ps2_rdn, ps2_clrn, ur_rdy_clr);
    end
    repeat (2) @(negedge clk_4);
    vb_rst = 1'b0;
    repeat (3) @(negedge clk_4);
    checks++;
    if (key !== 8'h00 || ps2_rdn !== 1'b1 || last_code !== 16'h0) begin
      errors++; $display("FAIL rst_release got=%h/%b/%h exp=00/1/0000", key, ps2_rdn, last_code);
    end
    model_clear();
  endtask

  initial begin
    plain_map[8'h1D] = 6; plain_map[8'h1B] = 7; plain_map[8'h1C] = 5; plain_map[8'h23] = 4;
    plain_map[8'h5A] = 3; plain_map[8'h29] = 2; plain_map[8'h4C] = 1; plain_map[8'h52] = 0;
    ext_map[8'h75] = 6; ext_map[8'h72] = 7; ext_map[8'h6B] = 5; ext_map[8'h74] = 4;
    test_reset();
    test_ps2_basic();
    test_ext();
    test_unmapped();
    test_random();
    test_uart();
    test_overflow();
    test_src_change();
    test_reset_mid_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
